clic_int_gateway: RTL and testbench
===================================

Name: clic_int_gateway

Overview:
- Per-source interrupt gateway directly upstream of the CLIC register adapter; its ip_o drives the adapter's ip_i.
- Synchronises raw interrupt lines, applies polarity and edge/level trigger selection from the clicintattr fields, and holds edge-triggered pending state.
- Edge pending state is cleared on arbiter acknowledge or set/cleared by software writes.
- Also reports sticky missed-edge status for debug.

Parameters:
- N_SOURCE, 32, number of interrupt sources.
- SYNC_STAGES, 2, synchroniser depth on src_i; 0 means bypass for sources already synchronous to clk_i.
- ID_W, $clog2(N_SOURCE), width of the acknowledge ID.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- src_i  in  N_SOURCE  raw interrupt lines.
- le_i  in  N_SOURCE  trigger type, from attr_trig[0]: 1 = edge, 0 = level.
- pol_i  in  N_SOURCE  polarity, from attr_trig[1]: 1 = active-low/falling, 0 = active-high/rising.
- sw_we_i  in  N_SOURCE  software write strobe to clicintip.
- sw_wdata_i  in  N_SOURCE  software write data to clicintip.
- ack_valid_i  in  1  arbiter claims an interrupt this cycle.
- ack_id_i  in  ID_W  ID of the claimed source.
- missed_clr_i  in  N_SOURCE  clear strobe for the missed flag.
- ip_o  out  N_SOURCE  registered pending bit per source.
- missed_o  out  N_SOURCE  sticky flag: an edge arrived while the source was already pending.

Behaviour:
- Reset values:
  - ip_o = 0, missed_o = 0.
  - Synchroniser flops = 0, prev_q = 0.
  - Warm-up counter = 0.
- Synchroniser: SYNC_STAGES flops per source → s[i]. Normalised level n[i] = s[i] XOR pol_i[i].
- prev_q[i] <= n[i] every cycle, regardless of mode. edge[i] = n[i] & ~prev_q[i] & warm.
- Warm-up:
  - A counter counts SYNC_STAGES+1 cycles after reset release; warm = 1 once the count is reached.
  - Suppresses spurious edges from flop initialisation, including an active-low source idling at 0.
  - Counter saturates; it never wraps.
- ack_hit[i] = ack_valid_i & (ack_id_i == i). An ack_id_i ≥ N_SOURCE is ignored.
- Level mode (le_i = 0):
  - ip_q[i] <= n[i] every cycle.
  - sw_we_i and ack are ignored; missed is not updated.
- Edge mode (le_i = 1), priority high to low:
  - edge → ip_q <= 1;
  - else sw_we_i → ip_q <= sw_wdata_i;
  - else ack_hit → ip_q <= 0;
  - else hold.
  - An edge coincident with ack or with a software clear keeps the source pending, so no event is lost.
- Missed flag:
  - Set when edge & le & ip_q & ~ack_hit, i.e. a second edge arrives before service.
  - Clear on missed_clr_i. Set wins over a simultaneous clear.
- Latency:
  - src_i transition → ip_o change = SYNC_STAGES+1 cycles (both modes).
  - ack/sw write → ip_o change = 1 cycle.
- Mode change:
  - Edge→level: ip follows n on the next cycle.
  - Level→edge: ip_q holds its current value. No spurious edge, because prev_q is tracked continuously.
- Polarity change: can produce a single edge if n flips 0→1. This is accepted behaviour; software clears ip after reconfiguring.
- Reset asserted mid-operation: all state returns to reset values asynchronously and warm-up restarts.
- ip_o and missed_o come straight from flops; there is no combinational path from inputs.

Decomposition:
- Shared package clic_pkg:
  - trigger-encoding constants TRIG_LEVEL = 1'b0, TRIG_EDGE = 1'b1, POL_POS = 1'b0, POL_NEG = 1'b1;
  - ack struct type clic_ack_t {valid, id}, parameterised by ID_W via typedef in the top.
- One sub-module, clic_gateway_cell, instantiated N_SOURCE times. It contains the synchroniser, prev_q, the pending flop and the missed flop.
- The top holds the warm-up counter and the ack_id decode.

Test Plan:
- Reset release with src_i = 0, pol_i[3] = 1, le_i[3] = 1 → ip_o[3] stays 0 through warm-up. Drive src_i[3] 1→0 at cycle 10 → ip_o[3] = 1 at cycle 13 (SYNC_STAGES = 2).
- Edge source 5, rising pulse → ip_o[5] = 1. Then ack_valid_i = 1, ack_id_i = 5 → ip_o[5] = 0 next cycle. Repeat with a second pulse landing the same cycle as the ack → ip_o[5] stays 1 and missed_o[5] stays 0.
- Two rising pulses on source 7 without ack → ip_o[7] = 1, missed_o[7] = 1. Then missed_clr_i[7] = 1 → missed_o[7] = 0. Set coincident with clear → missed_o[7] = 1.
- Level source 2: src_i[2] = 1 for 4 cycles → ip_o[2] = 1 for exactly those 4 cycles, delayed by 3. sw_we_i[2] = 1 with wdata 0, and an ack for ID 2, both leave ip_o[2] equal to n.
- Edge source 9: software write 1 → ip_o[9] = 1; write 0 → 0. ack_id_i = 40 with N_SOURCE = 32 → no bit changes.
- Assert rst_i mid-pending (ip_o = 0xFFFF_0000) → ip_o = 0 and missed_o = 0 immediately. Sources held high through reset release do not set edge pending.

Source files
------------

// File: rtl/clic_pkg.sv
// clic_pkg: encodings shared by the CLIC interrupt gateway and its per-source cell.
//   TRIG_LEVEL / TRIG_EDGE : attr_trig[0] values (trigger mode)
//   POL_POS / POL_NEG      : attr_trig[1] values (polarity)
//   normalise()            : maps a raw synchronised level to "active = 1"
package clic_pkg;

  localparam logic TRIG_LEVEL = 1'b0;
  localparam logic TRIG_EDGE  = 1'b1;
  localparam logic POL_POS    = 1'b0;
  localparam logic POL_NEG    = 1'b1;

  function automatic logic normalise(input logic lvl, input logic pol);
    case (pol)
      POL_POS: return lvl;
      POL_NEG: return ~lvl;
      default: return lvl;
    endcase
  endfunction

endpackage

// File: rtl/clic_gateway_cell.sv
// clic_gateway_cell: one interrupt source of the CLIC gateway.
// Holds the input synchroniser, the previous normalised level, the pending
// flop and the sticky missed-edge flop.
//   clk, rst      clock, asynchronous active-high reset
//   src           raw interrupt line
//   le, pol       trigger mode (1 = edge) and polarity (1 = active-low/falling)
//   sw_we/sw_wdata software write to the pending bit (edge mode only)
//   ack_hit       arbiter acknowledge decoded for this source
//   missed_clr    clear strobe for the missed flag
//   warm          edge detection enable after reset warm-up
//   ip, missed    registered pending bit and sticky missed-edge flag
module clic_gateway_cell
  import clic_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic le,
  input  logic pol,
  input  logic sw_we,
  input  logic sw_wdata,
  input  logic ack_hit,
  input  logic missed_clr,
  input  logic warm,
  output logic ip,
  output logic missed
);

  logic s;
  logic n;
  logic prev_q;
  logic edge_det;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign s = src;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= src;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  assign n        = normalise(s, pol);
  // prev_q tracks n in both modes, so a level->edge switch sees no false edge.
  assign edge_det = n & ~prev_q & warm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      ip     <= 1'b0;
      missed <= 1'b0;
    end else begin
      prev_q <= n;
      if (le == TRIG_LEVEL) begin
        ip <= n;
      end else if (edge_det) begin
        // A new edge outranks software clear and acknowledge: no event is lost.
        ip <= 1'b1;
      end else if (sw_we) begin
        ip <= sw_wdata;
      end else if (ack_hit) begin
        ip <= 1'b0;
      end
      if (le == TRIG_EDGE) begin
        if (edge_det && ip && !ack_hit) begin
          missed <= 1'b1;
        end else if (missed_clr) begin
          missed <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/clic_int_gateway.sv
// clic_int_gateway: per-source interrupt gateway feeding the CLIC register
// adapter (ip_o drives the adapter's ip_i).
//   clk_i, rst_i   clock, asynchronous active-high reset
//   src_i          raw interrupt lines
//   le_i, pol_i    trigger mode / polarity per source (from clicintattr)
//   sw_we_i, sw_wdata_i  software write to clicintip
//   ack_valid_i, ack_id_i  arbiter claim; IDs >= N_SOURCE are ignored
//   missed_clr_i   clear strobes for the missed flags
//   ip_o           registered pending bits
//   missed_o       sticky "edge arrived while already pending" flags
module clic_int_gateway
  import clic_pkg::*;
#(
  parameter int unsigned N_SOURCE    = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ID_W        = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] pol_i,
  input  logic [N_SOURCE-1:0] sw_we_i,
  input  logic [N_SOURCE-1:0] sw_wdata_i,
  input  logic                ack_valid_i,
  input  logic [ID_W-1:0]     ack_id_i,
  input  logic [N_SOURCE-1:0] missed_clr_i,
  output logic [N_SOURCE-1:0] ip_o,
  output logic [N_SOURCE-1:0] missed_o
);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } clic_ack_t;

  // Edge detection stays off until the synchroniser and prev_q hold real
  // samples, so reset values cannot masquerade as an edge.
  localparam int unsigned WARM_MAX = SYNC_STAGES + 1;
  localparam int unsigned CNT_W    = $clog2(WARM_MAX + 1);

  clic_ack_t           ack;
  logic [CNT_W-1:0]    warm_cnt;
  logic                warm;
  logic [N_SOURCE-1:0] ack_hit;

  assign ack  = '{valid: ack_valid_i, id: ack_id_i};
  assign warm = (warm_cnt == CNT_W'(WARM_MAX));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      warm_cnt <= '0;
    end else if (!warm) begin
      warm_cnt <= warm_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    ack_hit = '0;
    for (int unsigned i = 0; i < N_SOURCE; i++) begin
      ack_hit[i] = ack.valid && (32'(ack.id) == i);
    end
  end

  for (genvar g = 0; g < N_SOURCE; g++) begin : g_cell
    clic_gateway_cell #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cell (
      .clk        (clk_i),
      .rst        (rst_i),
      .src        (src_i[g]),
      .le         (le_i[g]),
      .pol        (pol_i[g]),
      .sw_we      (sw_we_i[g]),
      .sw_wdata   (sw_wdata_i[g]),
      .ack_hit    (ack_hit[g]),
      .missed_clr (missed_clr_i[g]),
      .warm       (warm),
      .ip         (ip_o[g]),
      .missed     (missed_o[g])
    );
  end

endmodule

// File: tb/tb_clic_int_gateway.sv
// tb_clic_int_gateway: self-checking bench for clic_int_gateway.
// A cycle-level behavioural model (sample history + edge count since reset)
// is compared against ip_o / missed_o on every negative clock edge; directed
// scenarios add hand-computed literal checks.
module tb_clic_int_gateway;

  localparam int unsigned N   = 32;
  localparam int unsigned SS  = 2;
  localparam int unsigned IDW = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   src, le, pol, sw_we, sw_wdata, missed_clr;
  logic           ack_valid;
  logic [IDW-1:0] ack_id;
  logic [N-1:0]   ip, missed;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clic_int_gateway #(
    .N_SOURCE   (N),
    .SYNC_STAGES(SS),
    .ID_W       (IDW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .src_i       (src),
    .le_i        (le),
    .pol_i       (pol),
    .sw_we_i     (sw_we),
    .sw_wdata_i  (sw_wdata),
    .ack_valid_i (ack_valid),
    .ack_id_i    (ack_id),
    .missed_clr_i(missed_clr),
    .ip_o        (ip),
    .missed_o    (missed)
  );

  // Model state: clock edges seen since reset release, the last SS samples of
  // src (oldest first), previous normalised level, pending and missed bits.
  typedef struct packed {
    logic [31:0]          edges;
    logic [N-1:0]         ip;
    logic [N-1:0]         missed;
    logic [N-1:0]         prevn;
    logic [SS-1:0][N-1:0] hist;
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t model_next(
    input mstate_t c, input logic [N-1:0] s_src, input logic [N-1:0] s_le,
    input logic [N-1:0] s_pol, input logic [N-1:0] s_we, input logic [N-1:0] s_wd,
    input logic s_av, input logic [IDW-1:0] s_aid, input logic [N-1:0] s_clr);
    mstate_t      x = c;
    logic [N-1:0] n;
    logic         warm, hit, e;
    n = c.hist[0] ^ s_pol;
    for (int k = 0; k < int'(SS) - 1; k++) x.hist[k] = c.hist[k+1];
    x.hist[SS-1] = s_src;
    warm = (c.edges >= SS + 1);
    x.edges = c.edges + 1;
    for (int i = 0; i < int'(N); i++) begin
      hit = s_av && (int'(s_aid) == i);
      e   = n[i] && !c.prevn[i] && warm;
      if (!s_le[i]) begin
        x.ip[i] = n[i];
      end else begin
        if (e) x.ip[i] = 1'b1;
        else if (s_we[i]) x.ip[i] = s_wd[i];
        else if (hit) x.ip[i] = 1'b0;
        if (e && c.ip[i] && !hit) x.missed[i] = 1'b1;
        else if (s_clr[i]) x.missed[i] = 1'b0;
      end
    end
    x.prevn = n;
    return x;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else m <= model_next(m, src, le, pol, sw_we, sw_wdata, ack_valid, ack_id, missed_clr);
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_ip", ip, m.ip);
    check("model_missed", missed, m.missed);
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    src = '0; le = '0; pol = '0; sw_we = '0; sw_wdata = '0; missed_clr = '0;
    ack_valid = 1'b0; ack_id = '0;
    le[3] = 1'b1; pol[3] = 1'b1; le[5] = 1'b1; le[7] = 1'b1; le[9] = 1'b1;
    tick(3);
    check("reset_ip", ip, 32'd0);
    check("reset_missed", missed, 32'd0);
    rst = 1'b0;

    // Active-low edge source idling at 0 must not pend after warm-up.
    tick(5);
    check("warmup_ip", ip, 32'd0);
    src[3] = 1'b1; tick(4); src[3] = 1'b0;
    tick(2); check("s3_before_lat", 32'(ip[3]), 32'd0);
    tick(1); check("s3_at_lat", 32'(ip[3]), 32'd1);

    // Source 5: pulse, ack, then pulse coincident with ack.
    src[5] = 1'b1; tick(1); src[5] = 1'b0; tick(2);
    check("s5_pend", 32'(ip[5]), 32'd1);
    ack_valid = 1'b1; ack_id = 6'd5; tick(1); ack_valid = 1'b0;
    check("s5_ack", 32'(ip[5]), 32'd0);
    src[5] = 1'b1; tick(1); src[5] = 1'b0; tick(2);
    src[5] = 1'b1; tick(1); src[5] = 1'b0; tick(1);
    ack_valid = 1'b1; tick(1); ack_valid = 1'b0;
    check("s5_edge_ack_ip", 32'(ip[5]), 32'd1);
    check("s5_edge_ack_missed", 32'(missed[5]), 32'd0);
    ack_valid = 1'b1; tick(1); ack_valid = 1'b0;
    check("s5_ack2", 32'(ip[5]), 32'd0);

    // Source 7: missed set, clear, set-beats-clear.
    src[7] = 1'b1; tick(1); src[7] = 1'b0; tick(2);
    src[7] = 1'b1; tick(1); src[7] = 1'b0; tick(2);
    check("s7_ip", 32'(ip[7]), 32'd1);
    check("s7_missed", 32'(missed[7]), 32'd1);
    missed_clr[7] = 1'b1; tick(1); missed_clr[7] = 1'b0;
    check("s7_clr", 32'(missed[7]), 32'd0);
    src[7] = 1'b1; tick(1); src[7] = 1'b0; tick(1);
    missed_clr[7] = 1'b1; tick(1); missed_clr[7] = 1'b0;
    check("s7_set_wins", 32'(missed[7]), 32'd1);

    // Level source 2: high for 4 cycles, seen 3 cycles later for 4 cycles.
    src[2] = 1'b1; tick(2);
    check("s2_lat2", 32'(ip[2]), 32'd0);
    tick(1); check("s2_lat3", 32'(ip[2]), 32'd1);
    tick(1); src[2] = 1'b0;
    tick(2); check("s2_last", 32'(ip[2]), 32'd1);
    tick(1); check("s2_fall", 32'(ip[2]), 32'd0);
    src[2] = 1'b1; tick(3);
    sw_we[2] = 1'b1; sw_wdata[2] = 1'b0; ack_valid = 1'b1; ack_id = 6'd2;
    tick(1); sw_we[2] = 1'b0; ack_valid = 1'b0;
    check("s2_ignore_sw_ack", 32'(ip[2]), 32'd1);
    src[2] = 1'b0;

    // Source 9: software set/clear, out-of-range acks.
    sw_we[9] = 1'b1; sw_wdata[9] = 1'b1; tick(1); sw_we[9] = 1'b0;
    check("s9_sw_set", 32'(ip[9]), 32'd1);
    sw_we[9] = 1'b1; sw_wdata[9] = 1'b0; tick(1); sw_we[9] = 1'b0;
    check("s9_sw_clr", 32'(ip[9]), 32'd0);
    sw_we[9] = 1'b1; sw_wdata[9] = 1'b1; tick(1); sw_we[9] = 1'b0;
    sw_wdata = '0;
    ack_valid = 1'b1; ack_id = 6'd40; tick(1);
    ack_id = 6'd41; tick(1); ack_valid = 1'b0;
    check("ack_oob_all", ip, 32'h0000_0288);

    // Randomised traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      if (c % 64 == 0) le = $urandom;
      if (c % 256 == 0) pol = $urandom;
      src        = $urandom;
      sw_we      = $urandom & $urandom & $urandom;
      sw_wdata   = $urandom;
      missed_clr = $urandom & $urandom & $urandom;
      ack_valid  = 1'($urandom_range(0, 1));
      ack_id     = IDW'($urandom_range(0, 63));
      tick(1);
    end

    // Reset asserted while sources are pending.
    src = '0; pol = '0; le = 32'hFFFF_0000; sw_we = '0; missed_clr = '0;
    ack_valid = 1'b0;
    tick(4);
    sw_we = 32'hFFFF_0000; sw_wdata = '1; tick(1); sw_we = '0;
    check("pre_reset_ip", ip, 32'hFFFF_0000);
    #1 rst = 1'b1;
    #1;
    check("async_reset_ip", ip, 32'd0);
    check("async_reset_missed", missed, 32'd0);
    src = '1; le = '1;
    tick(3);
    rst = 1'b0;
    tick(10);
    check("held_high_ip", ip, 32'd0);
    check("held_high_missed", missed, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
